// File: rtl/color_pkg.sv
// Shared colour-mixer definitions: default PWM geometry, channel indices
// and the duty-array type used by the colour-control logic.
package color_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 3;

  localparam int NUM_CH = 3;
  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;

  typedef logic [NUM_CH-1:0][DEF_WIDTH-1:0] duty_arr_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (pending + active) and the
// registered phase compare that drives the LED pin.
module pwm_channel
  import color_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] phase,
  input  logic             wrap,
  input  logic             load,
  input  logic             pending,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm
);

  logic [WIDTH-1:0] pend_duty;
  logic [WIDTH-1:0] act_duty;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pend_duty <= '0;
      act_duty  <= '0;
      pwm       <= 1'b0;
    end else begin
      if (load && !wrap) begin
        pend_duty <= duty;
      end
      // A load landing exactly on the boundary bypasses the pending stage.
      if (wrap) begin
        if (load) begin
          act_duty <= duty;
        end else if (pending) begin
          act_duty <= pend_duty;
        end
      end
      pwm <= (phase < act_duty);
    end
  end

endmodule

// File: rtl/rgb_pwm_mixer.sv
// Three-channel RGB PWM generator: prescaled shared phase counter, pending
// flag, and three double-buffered compare channels.
module rgb_pwm_mixer
  import color_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [WIDTH-1:0] duty_r,
  input  logic [WIDTH-1:0] duty_g,
  input  logic [WIDTH-1:0] duty_b,
  input  logic             load,
  output logic             pending,
  output logic             pwm_r,
  output logic             pwm_g,
  output logic             pwm_b,
  output logic             period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  pre;
  logic [WIDTH-1:0]  phase;
  logic              tick;
  logic              wrap;
  logic              pend_flag;
  logic [WIDTH-1:0]  duty_in [NUM_CH];
  logic [NUM_CH-1:0] pwm_vec;

  assign tick = (pre == PRE_MAX);
  assign wrap = tick && (phase == '1);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pre          <= '0;
      phase        <= '0;
      pend_flag    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre          <= tick ? '0 : pre + PRE_W'(1);
      period_start <= wrap;
      if (tick) begin
        phase <= phase + WIDTH'(1);
      end
      // The boundary always consumes the pending set, even if load coincides.
      if (wrap) begin
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_flag <= 1'b1;
      end
    end
  end

  assign duty_in[CH_R] = duty_r;
  assign duty_in[CH_G] = duty_g;
  assign duty_in[CH_B] = duty_b;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pwm_channel #(.WIDTH(WIDTH)) u_ch (
        .clk_in  (clk_in),
        .rst     (rst),
        .phase   (phase),
        .wrap    (wrap),
        .load    (load),
        .pending (pend_flag),
        .duty    (duty_in[gi]),
        .pwm     (pwm_vec[gi])
      );
    end
  endgenerate

  assign pwm_r   = pwm_vec[CH_R];
  assign pwm_g   = pwm_vec[CH_G];
  assign pwm_b   = pwm_vec[CH_B];
  assign pending = pend_flag;

endmodule

// File: tb/tb_rgb_pwm_mixer.sv
// Self-checking bench for rgb_pwm_mixer: scenario tasks plus a randomized
// run against a cycle-count based reference model.
module tb_rgb_pwm_mixer;

  localparam int W   = 8;
  localparam int P   = 3;
  localparam int PER = P * (1 << W);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [W-1:0] duty_r = '0, duty_g = '0, duty_b = '0;
  logic         load = 1'b0;
  logic         pending, pwm_r, pwm_g, pwm_b, period_start;

  logic         rst_s = 1'b1;
  logic [3:0]   duty_s_r = '0, duty_s_g = '0, duty_s_b = '0;
  logic         load_s = 1'b0;
  logic         pending_s, pwm_s_r, pwm_s_g, pwm_s_b, period_start_s;

  rgb_pwm_mixer #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk_in(clk), .rst(rst), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .load(load), .pending(pending), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .period_start(period_start)
  );

  rgb_pwm_mixer #(.WIDTH(4), .PRESCALE(1)) dut_s (
    .clk_in(clk), .rst(rst_s), .duty_r(duty_s_r), .duty_g(duty_s_g), .duty_b(duty_s_b),
    .load(load_s), .pending(pending_s), .pwm_r(pwm_s_r), .pwm_g(pwm_s_g), .pwm_b(pwm_s_b),
    .period_start(period_start_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time is the count of clock edges since reset release.
  int m_n;
  int m_act [3];
  int m_pv  [3];
  bit m_pend;
  bit m_pwm [3];
  bit m_ps;

  task automatic model_reset();
    m_n = 0; m_pend = 0; m_ps = 0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 0; m_pv[i] = 0; m_pwm[i] = 0;
    end
  endtask

  // Advance one clock edge; model consumes the inputs present at that edge.
  task automatic step();
    int d [3];
    bit ld, at_wrap;
    int cur_phase;
    d[0] = int'(duty_r); d[1] = int'(duty_g); d[2] = int'(duty_b);
    ld = load;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_n++;
      cur_phase = ((m_n - 1) / P) % (1 << W);
      at_wrap = (m_n % PER) == 0;
      for (int i = 0; i < 3; i++) m_pwm[i] = cur_phase < m_act[i];
      m_ps = at_wrap;
      if (at_wrap) begin
        for (int i = 0; i < 3; i++) m_act[i] = ld ? d[i] : (m_pend ? m_pv[i] : m_act[i]);
        m_pend = 0;
      end else if (ld) begin
        for (int i = 0; i < 3; i++) m_pv[i] = d[i];
        m_pend = 1;
      end
    end
  endtask

  task automatic do_load(input int r, input int g, input int b);
    duty_r = W'(r); duty_g = W'(g); duty_b = W'(b);
    load = 1'b1;
    step();
    load = 1'b0;
    duty_r = W'($urandom); duty_g = W'($urandom); duty_b = W'($urandom);
  endtask

  task automatic wait_ps(output bit ok);
    ok = 0;
    for (int i = 0; i < PER + 4; i++) begin
      step();
      if (period_start === 1'b1) begin
        ok = 1;
        return;
      end
    end
  endtask

  // Count high cycles per channel over the period that follows a period_start.
  task automatic measure(output int h [3], output int first_b, output int pend_hi);
    h[0] = 0; h[1] = 0; h[2] = 0; first_b = -1; pend_hi = 0;
    for (int i = 0; i < PER; i++) begin
      step();
      h[0] += int'(pwm_r); h[1] += int'(pwm_g); h[2] += int'(pwm_b);
      if (pwm_b === 1'b1 && first_b < 0) first_b = i;
      pend_hi += int'(pending);
    end
  endtask

  task automatic test_reset();
    int hi, ps_cnt, first_ps;
    #2;
    checks++;
    if ({pending, pwm_r, pwm_g, pwm_b, period_start} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=00000", {pending, pwm_r, pwm_g, pwm_b, period_start});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    hi = 0; ps_cnt = 0; first_ps = -1;
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      hi += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
      if (period_start === 1'b1) begin
        ps_cnt++;
        if (first_ps < 0) first_ps = m_n;
      end
    end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL reset_idle_pwm high=%0d exp=0", hi); end
    checks++;
    if (first_ps != PER) begin errors++; $display("FAIL reset_first_ps edge=%0d exp=%0d", first_ps, PER); end
    checks++;
    if (ps_cnt != 2) begin errors++; $display("FAIL reset_ps_count got=%0d exp=2", ps_cnt); end
    $display("reset: idle high=%0d first_ps=%0d ps_count=%0d", hi, first_ps, ps_cnt);
  endtask

  task automatic test_half();
    bit ok;
    int h [3];
    int fb, ph;
    for (int i = 0; i < 10; i++) step();
    do_load(128, 128, 128);
    step();
    checks++;
    if (pending !== 1'b1) begin errors++; $display("FAIL half_pending got=%b exp=1", pending); end
    wait_ps(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL half_wait_ps got=timeout exp=period_start"); end
    checks++;
    if (pending !== 1'b0) begin errors++; $display("FAIL half_pending_clear got=%b exp=0", pending); end
    measure(h, fb, ph);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (h[c] != 384) begin errors++; $display("FAIL half_high ch=%0d got=%0d exp=384", c, h[c]); end
    end
    $display("half: high r=%0d g=%0d b=%0d", h[0], h[1], h[2]);
  endtask

  task automatic test_extremes();
    bit ok;
    int h [3];
    int fb, ph;
    do_load(0, 255, 1);
    wait_ps(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ext_wait_ps got=timeout exp=period_start"); end
    measure(h, fb, ph);
    checks++;
    if (h[0] != 0) begin errors++; $display("FAIL ext_r got=%0d exp=0", h[0]); end
    checks++;
    if (h[1] != 765) begin errors++; $display("FAIL ext_g got=%0d exp=765", h[1]); end
    checks++;
    if (h[2] != 3) begin errors++; $display("FAIL ext_b got=%0d exp=3", h[2]); end
    checks++;
    if (fb != 0) begin errors++; $display("FAIL ext_b_start got=%0d exp=0", fb); end
    $display("extremes: r=%0d g=%0d b=%0d b_start=%0d", h[0], h[1], h[2], fb);
  endtask

  task automatic test_double_buffer();
    bit ok;
    int h [3];
    int fb, ph;
    wait_ps(ok);
    h[0] = 0; h[1] = 0; h[2] = 0;
    for (int i = 0; i < PER; i++) begin
      load = (i == 384 || i == 600);
      duty_r = (i == 384) ? 8'd64 : 8'd192;
      duty_g = duty_r; duty_b = duty_r;
      step();
      h[0] += int'(pwm_r); h[1] += int'(pwm_g); h[2] += int'(pwm_b);
    end
    load = 1'b0;
    checks++;
    if (h[0] != 0 || h[1] != 765 || h[2] != 3) begin
      errors++;
      $display("FAIL dbuf_current got=%0d/%0d/%0d exp=0/765/3", h[0], h[1], h[2]);
    end
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL dbuf_ps got=%b exp=1", period_start); end
    measure(h, fb, ph);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (h[c] != 576) begin errors++; $display("FAIL dbuf_next ch=%0d got=%0d exp=576", c, h[c]); end
    end
    $display("double_buffer: next r=%0d g=%0d b=%0d", h[0], h[1], h[2]);
  endtask

  task automatic test_coincident();
    int h [3];
    int fb, ph, pend_seen;
    pend_seen = 0;
    for (int i = 0; i < PER + 2 && ((m_n + 1) % PER) != 0; i++) begin
      step();
      pend_seen += int'(pending);
    end
    do_load(32, 32, 32);
    pend_seen += int'(pending);
    checks++;
    if (period_start !== 1'b1) begin errors++; $display("FAIL coin_ps got=%b exp=1", period_start); end
    measure(h, fb, ph);
    pend_seen += ph;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (h[c] != 96) begin errors++; $display("FAIL coin_high ch=%0d got=%0d exp=96", c, h[c]); end
    end
    checks++;
    if (pend_seen != 0) begin errors++; $display("FAIL coin_pending cycles=%0d exp=0", pend_seen); end
    $display("coincident: high=%0d pending_cycles=%0d", h[0], pend_seen);
  endtask

  task automatic test_random();
    int gap, bad;
    bad = 0;
    for (int t = 0; t < 8; t++) begin
      gap = $urandom_range(1, 700);
      for (int i = 0; i < gap; i++) begin
        step();
        checks++;
        if ({pending, period_start, pwm_b, pwm_g, pwm_r} !==
            {m_pend, m_ps, m_pwm[2], m_pwm[1], m_pwm[0]}) begin
          errors++; bad++;
          if (bad < 10)
            $display("FAIL random_cycle n=%0d got=%b exp=%b", m_n,
                     {pending, period_start, pwm_b, pwm_g, pwm_r},
                     {m_pend, m_ps, m_pwm[2], m_pwm[1], m_pwm[0]});
        end
      end
      do_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      $display("random: load %0d at edge %0d act=%0d/%0d/%0d", t, m_n, m_act[0], m_act[1], m_act[2]);
    end
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      checks++;
      if ({pending, period_start, pwm_b, pwm_g, pwm_r} !==
          {m_pend, m_ps, m_pwm[2], m_pwm[1], m_pwm[0]}) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL random_tail n=%0d got=%b exp=%b", m_n,
                   {pending, period_start, pwm_b, pwm_g, pwm_r},
                   {m_pend, m_ps, m_pwm[2], m_pwm[1], m_pwm[0]});
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int hi, ph;
    do_load(200, 200, 200);
    wait_ps(ok);
    for (int i = 0; i < 100; i++) step();
    do_load(50, 50, 50);
    checks++;
    if ({pending, pwm_r, pwm_g, pwm_b} !== 4'b1111) begin
      errors++; $display("FAIL midrst_pre got=%b exp=1111", {pending, pwm_r, pwm_g, pwm_b});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pending, pwm_r, pwm_g, pwm_b, period_start} !== 5'b0) begin
      errors++; $display("FAIL midrst_async got=%b exp=00000", {pending, pwm_r, pwm_g, pwm_b, period_start});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    hi = 0; ph = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      step();
      hi += int'(pwm_r) + int'(pwm_g) + int'(pwm_b);
      ph += int'(pending);
    end
    checks++;
    if (hi != 0) begin errors++; $display("FAIL midrst_idle_pwm high=%0d exp=0", hi); end
    checks++;
    if (ph != 0) begin errors++; $display("FAIL midrst_pending cycles=%0d exp=0", ph); end
    $display("mid_reset: idle high=%0d pending_cycles=%0d", hi, ph);
  endtask

  task automatic test_small();
    int h [3];
    int gap;
    bit found;
    rst_s = 1'b0;
    duty_s_r = 4'd5; duty_s_g = 4'd15; duty_s_b = 4'd0;
    load_s = 1'b1;
    step();
    load_s = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (period_start_s === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL small_wait_ps got=timeout exp=period_start"); end
    h[0] = 0; h[1] = 0; h[2] = 0; gap = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      h[0] += int'(pwm_s_r); h[1] += int'(pwm_s_g); h[2] += int'(pwm_s_b);
      if (period_start_s === 1'b1 && gap < 0) gap = i + 1;
    end
    checks++;
    if (h[0] != 5 || h[1] != 15 || h[2] != 0) begin
      errors++; $display("FAIL small_high got=%0d/%0d/%0d exp=5/15/0", h[0], h[1], h[2]);
    end
    checks++;
    if (gap != 16) begin errors++; $display("FAIL small_period got=%0d exp=16", gap); end
    $display("small: high r=%0d g=%0d b=%0d period=%0d", h[0], h[1], h[2], gap);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_half();
    test_extremes();
    test_double_buffer();
    test_coincident();
    test_random();
    test_mid_reset();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
